// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared constants for the lab-board key matrix scanner:
//   matrix geometry, scan FSM state encoding, button key indices,
//   and a lowest-set-bit helper used to produce key codes.
package keypad_scanner_pkg;

    localparam int KP_COLS = 4;
    localparam int KP_ROWS = 6;
    localparam int KP_KEYS = 24;

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_SAMPLE = 2'd1,
        S_UPDATE = 2'd2
    } scan_state_t;

    // Button keys occupy rows 4-5 of the matrix; A is the lowest index.
    typedef enum logic [4:0] {
        KEY_A = 5'd16,
        KEY_B = 5'd17,
        KEY_C = 5'd18,
        KEY_D = 5'd19,
        KEY_E = 5'd20,
        KEY_F = 5'd21,
        KEY_G = 5'd22,
        KEY_H = 5'd23
    } button_key_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [4:0] lowest_key(input logic [KP_KEYS-1:0] mask);
        logic [4:0] code;
        code = '0;
        for (int k = KP_KEYS - 1; k >= 0; k--) begin
            if (mask[k]) code = 5'(k);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_debounce_cell.sv
// key_debounce_cell
//   Debounces one matrix key. Evaluated once per scan frame (update=1);
//   a level change is accepted only after DEBOUNCE_FRAMES consecutive
//   frames disagree with the stable state.
// Ports
//   Clk     in   system clock
//   Reset   in   synchronous, active-high reset
//   update  in   one-cycle frame update strobe
//   raw     in   key level captured during the last frame (1 = pressed)
//   stable  out  debounced key level
//   rise    out  high in the update cycle that accepts a 0->1 change
module key_debounce_cell #(
    parameter int DEBOUNCE_FRAMES = 16,
    parameter int CNT_W           = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic update,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;

    assign differs = (raw != stable);
    assign accept  = update && differs && (cnt == CNT_W'(DEBOUNCE_FRAMES - 1));
    assign rise    = accept && raw;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (update) begin
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= raw;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans the 4-column x 6-row active-low key matrix, debounces every key
//   independently and presents the keypad (rows 0-3) and buttons A-H
//   (rows 4-5) words, plus a press strobe with the lowest new key code.
// Ports
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   kp_row_n[5:0] in   matrix rows, active low, asynchronous
//   kp_col_n[3:0] out  column drive, active low, one column low outside reset
//   keypad[15:0]  out  debounced keypad, bit = row*4+col
//   buttons_AtoH  out  debounced buttons, bit0 = A
//   key_press     out  one-cycle pulse when any key is newly pressed
//   key_code[4:0] out  lowest newly pressed key index, valid with key_press
//   frame_tick    out  high in the UPDATE cycle of every frame
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_SETTLE | column driven, waiting SETTLE_CYCLES for rows to settle
// S_SAMPLE | capture the six synchronised rows for the current column
// S_UPDATE | end of frame: apply debounce to all keys, restart at col 0
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 2500,
    parameter int DEBOUNCE_FRAMES = 16,
    parameter int CNT_W           = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [KP_ROWS-1:0]  kp_row_n,
    output logic [KP_COLS-1:0]  kp_col_n,
    output logic [15:0]         keypad,
    output logic [7:0]          buttons_AtoH,
    output logic                key_press,
    output logic [4:0]          key_code,
    output logic                frame_tick
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    scan_state_t        state, state_nxt;
    logic [1:0]         col, col_nxt;
    logic [SC_W-1:0]    settle_cnt, settle_nxt;
    logic               update;

    logic [KP_ROWS-1:0] row_meta;
    logic [KP_ROWS-1:0] row_sync;
    logic [KP_ROWS-1:0] row;
    logic [KP_KEYS-1:0] raw;
    logic [KP_KEYS-1:0] stable;
    logic [KP_KEYS-1:0] rise;

    // Rows are asynchronous to Clk; the settle time covers the sync latency.
    always_ff @(posedge Clk) begin
        row_meta <= kp_row_n;
        row_sync <= row_meta;
    end

    assign row = ~row_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_SETTLE;
            col        <= 2'd0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        settle_nxt = settle_cnt;
        update     = 1'b0;
        case (state)
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            S_SAMPLE: begin
                settle_nxt = '0;
                if (col == 2'd3) begin
                    state_nxt = S_UPDATE;
                end else begin
                    col_nxt   = col + 2'd1;
                    state_nxt = S_SETTLE;
                end
            end
            S_UPDATE: begin
                update    = 1'b1;
                col_nxt   = 2'd0;
                state_nxt = S_SETTLE;
            end
            default: begin
                state_nxt = S_SETTLE;
            end
        endcase
    end

    // Decoded straight from col so the column is released the moment Reset
    // is seen and exactly one column is low at all other times.
    always_comb begin
        kp_col_n = ~(4'b0001 << col);
        if (Reset) kp_col_n = 4'hF;
    end

    assign frame_tick = update;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            raw <= '0;
        end else if (state == S_SAMPLE) begin
            for (int r = 0; r < KP_ROWS; r++) begin
                raw[r*KP_COLS + int'(col)] <= row[r];
            end
        end
    end

    for (genvar k = 0; k < KP_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .Clk    (Clk),
            .Reset  (Reset),
            .update (update),
            .raw    (raw[k]),
            .stable (stable[k]),
            .rise   (rise[k])
        );
    end

    assign keypad       = stable[15:0];
    assign buttons_AtoH = stable[KEY_H:KEY_A];

    // rise is only ever set during UPDATE, so the strobe is one cycle wide
    // and lines up with the new stable image.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_press <= 1'b0;
            key_code  <= '0;
        end else begin
            key_press <= |rise;
            if (|rise) key_code <= lowest_key(rise);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic        Clk;
    logic        Reset;
    logic [5:0]  kp_row_n;
    logic [3:0]  kp_col_n;
    logic [15:0] keypad;
    logic [7:0]  buttons_AtoH;
    logic        key_press;
    logic [4:0]  key_code;
    logic        frame_tick;

    logic [23:0] key_down;
    int          checks;
    int          errors;
    int          press_cnt;

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_FRAMES (3),
        .CNT_W           (2)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .kp_row_n     (kp_row_n),
        .kp_col_n     (kp_col_n),
        .keypad       (keypad),
        .buttons_AtoH (buttons_AtoH),
        .key_press    (key_press),
        .key_code     (key_code),
        .frame_tick   (frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        kp_row_n = 6'h3F;
        for (int r = 0; r < 6; r++) begin
            kp_row_n[r] = ~|(key_down[r*4 +: 4] & ~kp_col_n);
        end
    end

    always @(posedge Clk) begin
        if (key_press === 1'b1) press_cnt++;
    end

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        if (frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout frame_tick=%b want 1", frame_tick);
        end
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] exp_col;
        int         p;
        one      = 4'b0001;
        Reset    = 1'b1;
        key_down = '0;
        repeat (5) @(negedge Clk);
        checks++;
        if (kp_col_n !== 4'hF) begin errors++; $display("FAIL reset_col got %h want F", kp_col_n); end
        checks++;
        if (keypad !== 16'h0 || buttons_AtoH !== 8'h0) begin
            errors++; $display("FAIL reset_outputs got %h/%h want 0/0", keypad, buttons_AtoH);
        end
        checks++;
        if (key_press !== 1'b0 || key_code !== 5'd0 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got %b/%0d/%b want 0/0/0", key_press, key_code, frame_tick);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (kp_col_n !== 4'hE) begin errors++; $display("FAIL release_col got %h want E", kp_col_n); end
        for (int i = 1; i <= 41; i++) begin
            @(negedge Clk);
            p       = i % 21;
            exp_col = (p < 20) ? ~(one << (p / 5)) : 4'h7;
            checks++;
            if (kp_col_n !== exp_col) begin
                errors++; $display("FAIL scan_col cycle %0d got %h want %h", i, kp_col_n, exp_col);
            end
            checks++;
            if (frame_tick !== (p == 20)) begin
                errors++; $display("FAIL frame_tick cycle %0d got %b want %b", i, frame_tick, (p == 20));
            end
        end
        checks++;
        if (keypad !== 16'h0 || press_cnt != 0) begin
            errors++; $display("FAIL idle_keys got %h presses %0d want 0 0", keypad, press_cnt);
        end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = press_cnt;
        wait_frame();
        key_down[6] = 1'b1;
        wait_frame();
        wait_frame();
        key_down[6] = 1'b0;
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0) begin errors++; $display("FAIL bounce_2frames got %h want 0000", keypad); end
        wait_frame();
        key_down[6] = 1'b1;
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0) begin errors++; $display("FAIL bounce_gap got %h want 0000", keypad); end
        wait_frame();
        wait_frame();
        key_down[6] = 1'b0;
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0) begin errors++; $display("FAIL bounce_again got %h want 0000", keypad); end
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0 || press_cnt != p0) begin
            errors++; $display("FAIL bounce_final got %h presses %0d want 0000 %0d", keypad, press_cnt, p0);
        end
    endtask

    task automatic test_press();
        wait_frame();
        key_down[6] = 1'b1;
        wait_frame();
        @(negedge Clk);
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0) begin errors++; $display("FAIL press_early got %h want 0000", keypad); end
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0040) begin errors++; $display("FAIL press_keypad got %h want 0040", keypad); end
        checks++;
        if (key_press !== 1'b1 || key_code !== 5'd6) begin
            errors++; $display("FAIL press_strobe got %b code %0d want 1 code 6", key_press, key_code);
        end
        @(negedge Clk);
        checks++;
        if (key_press !== 1'b0) begin errors++; $display("FAIL press_width got %b want 0", key_press); end
    endtask

    task automatic test_release();
        int p0;
        p0 = press_cnt;
        key_down[6] = 1'b0;
        wait_frame();
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0040) begin errors++; $display("FAIL release_early got %h want 0040", keypad); end
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0) begin errors++; $display("FAIL release_keypad got %h want 0000", keypad); end
        repeat (3) @(negedge Clk);
        checks++;
        if (press_cnt != p0) begin errors++; $display("FAIL release_pulse got %0d want %0d", press_cnt, p0); end
    endtask

    task automatic test_simultaneous();
        int p0;
        wait_frame();
        key_down[3]  = 1'b1;
        key_down[20] = 1'b1;
        p0 = press_cnt;
        wait_frame();
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0 || buttons_AtoH !== 8'h0) begin
            errors++; $display("FAIL multi_early got %h/%h want 0000/00", keypad, buttons_AtoH);
        end
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0008 || buttons_AtoH !== 8'h10) begin
            errors++; $display("FAIL multi_state got %h/%h want 0008/10", keypad, buttons_AtoH);
        end
        checks++;
        if (key_press !== 1'b1 || key_code !== 5'd3) begin
            errors++; $display("FAIL multi_strobe got %b code %0d want 1 code 3", key_press, key_code);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (press_cnt != p0 + 1) begin errors++; $display("FAIL multi_count got %0d want %0d", press_cnt, p0 + 1); end
    endtask

    task automatic test_reset_midframe();
        int n;
        wait_frame();
        key_down = '0;
        key_down[6] = 1'b1;
        wait_frame();
        wait_frame();
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0040 || buttons_AtoH !== 8'h0) begin
            errors++; $display("FAIL swap_state got %h/%h want 0040/00", keypad, buttons_AtoH);
        end
        n = 0;
        while (kp_col_n !== 4'hB && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (kp_col_n !== 4'hB) begin errors++; $display("FAIL col2_timeout got %h want B", kp_col_n); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0 || buttons_AtoH !== 8'h0 || kp_col_n !== 4'hF) begin
            errors++; $display("FAIL midreset got %h/%h/%h want 0000/00/F", keypad, buttons_AtoH, kp_col_n);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (kp_col_n !== 4'hE) begin errors++; $display("FAIL midreset_col got %h want E", kp_col_n); end
        wait_frame();
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0) begin errors++; $display("FAIL midreset_early got %h want 0000", keypad); end
        wait_frame();
        @(negedge Clk);
        checks++;
        if (keypad !== 16'h0040 || key_press !== 1'b1 || key_code !== 5'd6) begin
            errors++;
            $display("FAIL midreset_return got %h %b code %0d want 0040 1 code 6", keypad, key_press, key_code);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        press_cnt = 0;
        Reset     = 1'b1;
        key_down  = '0;
        test_reset();
        test_bounce();
        test_press();
        test_release();
        test_simultaneous();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
